csa_accumulator: RTL
====================

CSA_ACCUMULATOR -- requirements
Module: csa_accumulator

Interface
REQ-001 SHALL have parameter DW, default 4: operand width in bits.
REQ-002 SHALL have parameter AW, default 8: accumulator and result width in bits.
REQ-003 SHALL have parameter MAX_OPS, default 16: maximum number of operands per frame.
REQ-004 SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_n, input, 1: reset, asynchronous and active-low.
REQ-006 SHALL have port in_valid, input, 1: in_data and in_last are valid.
REQ-007 SHALL have port in_data, input, DW: unsigned operand.
REQ-008 SHALL have port in_last, input, 1: marks the final operand of a frame.
REQ-009 SHALL have port in_ready, output, 1: the block can accept an operand.
REQ-010 SHALL have port out_valid, output, 1: out_data and out_count are valid.
REQ-011 SHALL have port out_data, output, AW: resolved frame sum, modulo 2^AW.
REQ-012 SHALL have port out_count, output, 5: number of operands in the frame (1..MAX_OPS).
REQ-013 SHALL have port out_ready, input, 1: the consumer accepts the result.

Function
REQ-014 SHALL implement a three-state FSM: ACCUM, RESOLVE and OUTPUT.
REQ-015 SHALL drive in_ready=1 only in ACCUM and out_valid=1 only in OUTPUT.
REQ-016 SHALL hold redundant registers S[AW-1:0] and C[AW-1:0], plus an operand counter cnt.
REQ-017 SHALL, on each accept (in_valid and in_ready), perform one 3:2 compression of S, C and zero-extended in_data:
  - S' = S xor C xor op
  - C' = (majority(S, C, op) << 1), truncated to AW
  - cnt increments by 1
REQ-018 SHALL leave all state unchanged in cycles where in_valid=0.
REQ-019 SHALL move ACCUM->RESOLVE on the cycle that accepts an operand with in_last=1, or that accepts the MAX_OPS-th operand, whichever comes first.
REQ-020 SHALL perform RESOLVE bit-serially:
  - exactly AW cycles, one bit per cycle, LSB first
  - each bit = S[i] xor C[i] xor cy, with cy registered
  - the final carry is discarded (modulo 2^AW)
REQ-021 SHALL move RESOLVE->OUTPUT after the AW-th resolve cycle.
REQ-022 SHALL assert out_valid from cycle T+AW+1, where T is the cycle that accepted the last operand; the default latency is 9 cycles.
REQ-023 SHALL hold out_data and out_count stable in OUTPUT until out_ready=1.
REQ-024 SHALL, on the out_valid and out_ready handshake:
  - clear S, C, cnt and the result register
  - return to ACCUM, so in_ready=1 on the next cycle
REQ-025 SHALL ignore in_valid outside ACCUM; no operand is lost because in_ready=0 there.
REQ-026 SHALL drive out_data=0 and out_count=0 whenever out_valid=0.
REQ-027 SHALL never produce an empty frame; every frame contains at least one operand.

Reset
REQ-028 SHALL, while rst_n=0 and independent of clk:
  - force state to ACCUM
  - clear S, C, cnt, carry and the result register to 0
REQ-029 SHALL, during and immediately after reset, output in_ready=1, out_valid=0, out_data=0 and out_count=0.
REQ-030 SHALL discard any partial frame or resolve in progress when reset is asserted; no result is emitted for it.

Structure
REQ-031 SHALL place the state enum and the default constants DW, AW and MAX_OPS in the shared package csa_acc_pkg.
REQ-032 SHALL build both the compression row (AW instances) and the serial resolve bit (one instance) from the existing full_adder sub-module (a, b, cin, sum, cout).

Verification
REQ-033 SHALL test a normal frame: inputs 3, 5, 7 with last on 7 -> out_data=15, out_count=3, out_valid exactly 9 cycles after the accept of 7.
REQ-034 SHALL test auto-termination: 16 operands of 15, in_last never asserted -> out_data=240, out_count=16, in_ready=0 from the cycle after the 16th accept.
REQ-035 SHALL test a single-operand frame: input 9 with in_last -> out_data=9, out_count=1.
REQ-036 SHALL test backpressure: out_ready held low 5 cycles in OUTPUT -> out_data and out_count stable and in_ready=0; after the handshake, in_ready=1 next cycle, and a next frame of 1, 2 gives 3.
REQ-037 SHALL test mid-resolve reset: rst_n pulsed low during RESOLVE -> outputs 0 and in_ready=1 immediately, no out_valid; a following frame of 4, 4 gives 8.
REQ-038 SHALL test input bubbles: in_valid low on alternate cycles over inputs 2, 6, 10 -> no state change in the gap cycles, out_data=18, out_count=3.

Source files
------------

// File: rtl/csa_acc_pkg.sv
// Shared definitions for the carry-save accumulator.
//   csa_state_t : controller states (ACCUM, RESOLVE, OUTPUT)
//   DW/AW/MAX_OPS defaults : operand width, accumulator width, frame length cap
package csa_acc_pkg;

  localparam int CSA_DW      = 4;
  localparam int CSA_AW      = 8;
  localparam int CSA_MAX_OPS = 16;

  typedef enum logic [1:0] {
    ACCUM   = 2'd0,
    RESOLVE = 2'd1,
    OUTPUT  = 2'd2
  } csa_state_t;

endpackage

// File: rtl/full_adder.sv
// One-bit full adder.
//   a, b, cin : addend bits
//   sum, cout : sum bit and carry out (majority of the three inputs)
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/csa_accumulator.sv
// Frame accumulator that keeps its running sum in carry-save form (S, C),
// then resolves it bit-serially before presenting the result.
//   clk, rst_n            : clock, async active-low reset
//   in_valid/in_ready     : operand handshake; in_data operand, in_last ends frame
//   out_valid/out_ready   : result handshake; out_data sum mod 2^AW, out_count operands
module csa_accumulator
  import csa_acc_pkg::*;
#(
  parameter int DW      = CSA_DW,
  parameter int AW      = CSA_AW,
  parameter int MAX_OPS = CSA_MAX_OPS
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  input  logic          in_last,
  output logic          in_ready,
  output logic          out_valid,
  output logic [AW-1:0] out_data,
  output logic [4:0]    out_count,
  input  logic          out_ready
);

  localparam int RW = (AW > 1) ? $clog2(AW) : 1;

  csa_state_t    state, state_nxt;
  logic [AW-1:0] s_q, c_q, res_q;
  logic [AW-1:0] op, s_nxt, maj, c_nxt;
  logic [4:0]    cnt;
  logic [RW-1:0] ridx;
  logic          cy_q, rbit, rcy;
  logic          accept, last_op, last_bit;

  assign in_ready  = (state == ACCUM);
  assign out_valid = (state == OUTPUT);
  assign out_data  = out_valid ? res_q : '0;
  assign out_count = out_valid ? cnt   : '0;

  assign accept   = in_valid & in_ready;
  assign last_op  = in_last | (cnt == 5'(MAX_OPS - 1));
  assign last_bit = (ridx == RW'(AW - 1));

  // 3:2 compression row: sum bits become S, majority bits shifted up become C.
  assign op = AW'(in_data);

  for (genvar i = 0; i < AW; i++) begin : g_csa
    full_adder u_fa (
      .a   (s_q[i]),
      .b   (c_q[i]),
      .cin (op[i]),
      .sum (s_nxt[i]),
      .cout(maj[i])
    );
  end

  assign c_nxt = maj << 1;

  // Serial resolve: one bit of S + C per cycle, carry held in cy_q.
  full_adder u_rfa (
    .a   (s_q[ridx]),
    .b   (c_q[ridx]),
    .cin (cy_q),
    .sum (rbit),
    .cout(rcy)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      ACCUM:   if (accept && last_op) state_nxt = RESOLVE;
      RESOLVE: if (last_bit)          state_nxt = OUTPUT;
      OUTPUT:  if (out_ready)         state_nxt = ACCUM;
      default:                        state_nxt = ACCUM;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ACCUM;
      s_q   <= '0;
      c_q   <= '0;
      res_q <= '0;
      cnt   <= '0;
      ridx  <= '0;
      cy_q  <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        ACCUM: begin
          if (accept) begin
            s_q <= s_nxt;
            c_q <= c_nxt;
            cnt <= cnt + 5'd1;
          end
        end
        RESOLVE: begin
          // Bits enter at the MSB and shift down; after AW cycles bit 0 is the LSB.
          res_q <= {rbit, res_q[AW-1:1]};
          cy_q  <= rcy;
          ridx  <= last_bit ? '0 : ridx + RW'(1);
        end
        OUTPUT: begin
          if (out_ready) begin
            s_q   <= '0;
            c_q   <= '0;
            res_q <= '0;
            cnt   <= '0;
            cy_q  <= 1'b0;
            ridx  <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
